auto_load_seq_ctrl: RTL and testbench
=====================================

# auto_load_seq_ctrl

Parametrised multi-sequence auto-load controller for the DCFEB I2C configuration path. It replaces the single-shot auto-load FSM and sits between the auto-load data source, which raises AL_DATA_RDY, and the I2C sequencer, which returns SEQ_DONE and SEQ_ERR. It steps through NSEQ load sequences in order, with a programmable sync hold, a per-sequence watchdog and bounded retries. It ends in a re-armable DONE or FAIL state instead of locking up in address-clear.

## Interface
Parameters:
- NSEQ, 4: number of load sequences run per auto-load pass (1..16).
- SYNC_CYC, 1: cycles SYNC is held before each START (1..15).
- TMO_W, 16: watchdog width; timeout after 2^TMO_W RUN cycles.
- MAX_RETRY, 2: retries allowed per sequence (0..7).
- SEQ_W, derived: width of SEQ_SEL, max(1, clog2(NSEQ)).

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  reset, asynchronous and active-low.
- AL_DATA_RDY  in  1  auto-load data is valid; starts a pass from IDLE.
- SEQ_DONE  in  1  sequencer finished the current sequence (1-cycle pulse or level).
- SEQ_ERR  in  1  sequencer reported a NACK or bus error.
- REARM  in  1  leave DONE or FAIL and return to IDLE.
- CLR_ADDR  out  1  clear the sequencer address pointer.
- SYNC  out  1  sync strobe to the sequencer.
- START_AL  out  1  run the auto-load sequence (level).
- USE_AL_DATA  out  1  mux select that routes auto-load data to the sequencer.
- SEQ_SEL  out  SEQ_W  index of the current sequence.
- AL_DONE  out  1  all sequences completed (level).
- AL_FAIL  out  1  pass aborted after retries ran out (level).
- RETRY_TOT  out  8  retries since leaving IDLE, saturating at 255.

## Operation
- States (3-bit encoding): IDLE, SYNC, RUN, DONE, FAIL.
- All outputs are registered and decoded from the next state, so each output changes on the same edge the state changes.
- Reset: state = IDLE and every output = 0. CLR_ADDR rises on the first CLK edge after RST_N deasserts.
- IDLE: CLR_ADDR=1.
  - AL_DATA_RDY=1 → SYNC, with SEQ_SEL=0, retry=0, RETRY_TOT=0.
- SYNC: SYNC=1, USE_AL_DATA=1 for exactly SYNC_CYC cycles, then → RUN.
- RUN: START_AL=1, USE_AL_DATA=1. The watchdog is 0 on the first RUN cycle and increments every RUN cycle. Priority in a RUN cycle, highest first:
  - SEQ_ERR=1 → error path.
  - SEQ_DONE=1 and SEQ_SEL=NSEQ-1 → DONE.
  - SEQ_DONE=1 and SEQ_SEL<NSEQ-1 → SEQ_SEL+1, retry=0, → SYNC.
  - watchdog = all-ones → error path.
- Error path:
  - retry<MAX_RETRY: retry+1, RETRY_TOT+1 (saturating), → SYNC with SEQ_SEL unchanged.
  - otherwise → FAIL.
- DONE: CLR_ADDR=1, AL_DONE=1.
- FAIL: CLR_ADDR=1, AL_FAIL=1; SEQ_SEL holds the failing index.
- DONE and FAIL both hold until REARM=1, then → IDLE.
- REARM is ignored in IDLE, SYNC and RUN.
- AL_DATA_RDY is ignored outside IDLE.
- SEQ_DONE and SEQ_ERR are ignored outside RUN.
- Asserting RST_N low in any state returns to IDLE with all outputs 0 immediately, without waiting for a clock edge.

## Timing
- AL_DATA_RDY sampled high at edge k:
  - SYNC high for edges k+1 .. k+SYNC_CYC.
  - START_AL high from edge k+SYNC_CYC+1.
- SEQ_DONE sampled at edge m with more sequences remaining: START_AL falls and SYNC rises at m+1; SEQ_SEL updates at m+1.
- Last SEQ_DONE at edge m: AL_DONE and CLR_ADDR rise at m+1.
- Timeout: the 2^TMO_W-th RUN cycle takes the error path. START_AL covers exactly 2^TMO_W cycles.
- REARM at edge r: AL_DONE/AL_FAIL fall at r+1; CLR_ADDR stays high.
- AL_DATA_RDY held high through DONE and REARM: the next pass begins one cycle after IDLE is entered.
- SEQ_DONE held as a level: each RUN entry consumes it at its first cycle.

## Structure
- Shared package auto_load_pkg holds:
  - state encoding constants for IDLE, SYNC, RUN, DONE, FAIL;
  - the clog2 function;
  - the RETRY_TOT width constant (8).
- One sub-module: al_watchdog, a TMO_W-bit counter with clear, enable and terminal-count outputs.
- The FSM, the SYNC_CYC hold counter and the retry counters live in the top module.

## Test plan
- Reset then idle, NSEQ=4, SYNC_CYC=2: release RST_N → CLR_ADDR=1 one edge later; START_AL, SYNC, USE_AL_DATA, AL_DONE, AL_FAIL all 0.
- Full pass: pulse AL_DATA_RDY, answer each RUN with SEQ_DONE after 5 cycles → SEQ_SEL steps 0,1,2,3; each step is preceded by 2 SYNC cycles; AL_DONE=1, RETRY_TOT=0. REARM → IDLE.
- Retry then success, MAX_RETRY=2: SEQ_ERR on sequence 1 twice, then SEQ_DONE → SEQ_SEL stays 1 across three SYNC/RUN rounds; RETRY_TOT=2; pass ends in AL_DONE.
- Timeout to fail, TMO_W=4, MAX_RETRY=1: never assert SEQ_DONE → START_AL is high for 16 cycles, twice; then AL_FAIL=1, SEQ_SEL=0, RETRY_TOT=1.
- Simultaneous events: SEQ_DONE and SEQ_ERR in the same cycle → retry taken. SEQ_DONE in the terminal watchdog cycle → counted as success.
- Reset mid-RUN: drop RST_N while START_AL=1 → all outputs 0 immediately; after release, CLR_ADDR=1 and SEQ_SEL=0.

Source files
------------

// File: rtl/auto_load_pkg.sv
// Shared definitions for the DCFEB auto-load sequence controller.
// Latency: n/a (types, constants and an elaboration-time helper only).
// Backpressure: n/a.
package auto_load_pkg;

    // Controller states; the 3-bit encoding is visible in debug captures.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SYNC = 3'd1,
        ST_RUN  = 3'd2,
        ST_DONE = 3'd3,
        ST_FAIL = 3'd4
    } al_state_t;

    // Width of the saturating retry total reported to software.
    localparam int RETRY_TOT_W = 8;

    // Ceiling log2, used only on parameters at elaboration time.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >>> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/al_watchdog.sv
// Per-sequence watchdog: counts cycles while enabled, flags the all-ones count.
// Latency: tc is combinational from the count; the count moves one step per CLK.
// Backpressure: none; clr wins over en.
// Ports: CLK/RST_N clock and async active-low reset, clr zeroes the count,
//        en advances it, tc is high while enabled on the terminal count.
module al_watchdog #(
    parameter int TMO_W = 16
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [TMO_W-1:0] cnt;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + TMO_W'(1);
        end
    end

    // Terminal when the 2^TMO_W-th enabled cycle is in progress.
    assign tc = en & (&cnt);

endmodule

// File: rtl/auto_load_seq_ctrl.sv
// Multi-sequence auto-load controller: SYNC hold, RUN with watchdog, bounded retries, DONE/FAIL.
// Latency: all outputs registered from the next state, changing on the same edge as the state.
// Backpressure: waits indefinitely on AL_DATA_RDY in IDLE and REARM in DONE/FAIL; RUN is watchdog-bounded.
// Ports: AL_DATA_RDY/SEQ_DONE/SEQ_ERR/REARM in; CLR_ADDR, SYNC, START_AL, USE_AL_DATA,
//        SEQ_SEL, AL_DONE, AL_FAIL, RETRY_TOT out to the I2C sequencer and status.
module auto_load_seq_ctrl
    import auto_load_pkg::*;
#(
    parameter  int NSEQ      = 4,
    parameter  int SYNC_CYC  = 1,
    parameter  int TMO_W     = 16,
    parameter  int MAX_RETRY = 2,
    localparam int SEQ_W     = (NSEQ > 1) ? clog2(NSEQ) : 1
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   AL_DATA_RDY,
    input  logic                   SEQ_DONE,
    input  logic                   SEQ_ERR,
    input  logic                   REARM,
    output logic                   CLR_ADDR,
    output logic                   SYNC,
    output logic                   START_AL,
    output logic                   USE_AL_DATA,
    output logic [SEQ_W-1:0]       SEQ_SEL,
    output logic                   AL_DONE,
    output logic                   AL_FAIL,
    output logic [RETRY_TOT_W-1:0] RETRY_TOT
);

    localparam logic [SEQ_W-1:0] LAST_SEQ  = SEQ_W'(NSEQ - 1);
    localparam logic [3:0]       SYNC_LAST = 4'(SYNC_CYC - 1);
    localparam logic [2:0]       RETRY_MAX = 3'(MAX_RETRY);

    al_state_t              state, state_nxt;
    logic [3:0]             sync_cnt, sync_cnt_nxt;
    logic [2:0]             retry, retry_nxt;
    logic [SEQ_W-1:0]       seq_sel_nxt;
    logic [RETRY_TOT_W-1:0] retry_tot_nxt;
    logic                   run_err;
    logic                   wd_tc;
    logic                   clr_addr_nxt, sync_nxt, start_al_nxt, use_al_data_nxt;
    logic                   al_done_nxt, al_fail_nxt;

    al_watchdog #(.TMO_W(TMO_W)) u_watchdog (
        .CLK   (CLK),
        .RST_N (RST_N),
        .clr   (state != ST_RUN),
        .en    (state == ST_RUN),
        .tc    (wd_tc)
    );

    // State, counters and registered outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= ST_IDLE;
            sync_cnt    <= '0;
            retry       <= '0;
            SEQ_SEL     <= '0;
            RETRY_TOT   <= '0;
            CLR_ADDR    <= 1'b0;
            SYNC        <= 1'b0;
            START_AL    <= 1'b0;
            USE_AL_DATA <= 1'b0;
            AL_DONE     <= 1'b0;
            AL_FAIL     <= 1'b0;
        end else begin
            state       <= state_nxt;
            sync_cnt    <= sync_cnt_nxt;
            retry       <= retry_nxt;
            SEQ_SEL     <= seq_sel_nxt;
            RETRY_TOT   <= retry_tot_nxt;
            CLR_ADDR    <= clr_addr_nxt;
            SYNC        <= sync_nxt;
            START_AL    <= start_al_nxt;
            USE_AL_DATA <= use_al_data_nxt;
            AL_DONE     <= al_done_nxt;
            AL_FAIL     <= al_fail_nxt;
        end
    end

    // Next state and counter updates.
    always_comb begin
        state_nxt     = state;
        sync_cnt_nxt  = '0;       // hold counter only runs inside SYNC
        retry_nxt     = retry;
        seq_sel_nxt   = SEQ_SEL;
        retry_tot_nxt = RETRY_TOT;
        run_err       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (AL_DATA_RDY) begin
                    state_nxt     = ST_SYNC;
                    seq_sel_nxt   = '0;
                    retry_nxt     = '0;
                    retry_tot_nxt = '0;
                end
            end
            ST_SYNC: begin
                if (sync_cnt == SYNC_LAST) begin
                    state_nxt = ST_RUN;
                end else begin
                    sync_cnt_nxt = sync_cnt + 4'd1;
                end
            end
            ST_RUN: begin
                // Error beats completion; completion beats the watchdog.
                if (SEQ_ERR) begin
                    run_err = 1'b1;
                end else if (SEQ_DONE) begin
                    if (SEQ_SEL == LAST_SEQ) begin
                        state_nxt = ST_DONE;
                    end else begin
                        seq_sel_nxt = SEQ_SEL + SEQ_W'(1);
                        retry_nxt   = '0;
                        state_nxt   = ST_SYNC;
                    end
                end else if (wd_tc) begin
                    run_err = 1'b1;
                end
                if (run_err) begin
                    if (retry < RETRY_MAX) begin
                        retry_nxt = retry + 3'd1;
                        if (RETRY_TOT != '1) begin
                            retry_tot_nxt = RETRY_TOT + RETRY_TOT_W'(1);
                        end
                        state_nxt = ST_SYNC;
                    end else begin
                        state_nxt = ST_FAIL;
                    end
                end
            end
            ST_DONE, ST_FAIL: begin
                if (REARM) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state so outputs move with the state edge.
    always_comb begin
        clr_addr_nxt    = (state_nxt == ST_IDLE) || (state_nxt == ST_DONE) || (state_nxt == ST_FAIL);
        sync_nxt        = (state_nxt == ST_SYNC);
        start_al_nxt    = (state_nxt == ST_RUN);
        use_al_data_nxt = (state_nxt == ST_SYNC) || (state_nxt == ST_RUN);
        al_done_nxt     = (state_nxt == ST_DONE);
        al_fail_nxt     = (state_nxt == ST_FAIL);
    end

endmodule

// File: tb/tb_auto_load_seq_ctrl.sv
// Bench for auto_load_seq_ctrl: directed scenarios plus random traffic, outputs compared
// every cycle against a phase-level reference model, with literal spot checks.
module tb_auto_load_seq_ctrl;

    localparam int NSEQ      = 4;
    localparam int SYNC_CYC  = 2;
    localparam int TMO_W     = 4;
    localparam int MAX_RETRY = 2;
    localparam int SEQ_W     = 2;
    localparam int TMO_CYC   = 1 << TMO_W;

    logic CLK = 1'b0;
    logic RST_N = 1'b1;
    logic AL_DATA_RDY = 1'b0;
    logic SEQ_DONE = 1'b0;
    logic SEQ_ERR = 1'b0;
    logic REARM = 1'b0;
    logic CLR_ADDR, SYNC, START_AL, USE_AL_DATA, AL_DONE, AL_FAIL;
    logic [SEQ_W-1:0] SEQ_SEL;
    logic [7:0] RETRY_TOT;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    always #5 CLK = ~CLK;

    auto_load_seq_ctrl #(
        .NSEQ(NSEQ), .SYNC_CYC(SYNC_CYC), .TMO_W(TMO_W), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .AL_DATA_RDY(AL_DATA_RDY), .SEQ_DONE(SEQ_DONE),
        .SEQ_ERR(SEQ_ERR), .REARM(REARM), .CLR_ADDR(CLR_ADDR), .SYNC(SYNC),
        .START_AL(START_AL), .USE_AL_DATA(USE_AL_DATA), .SEQ_SEL(SEQ_SEL),
        .AL_DONE(AL_DONE), .AL_FAIL(AL_FAIL), .RETRY_TOT(RETRY_TOT)
    );

    // Reference model: which phase of a pass we are in, SYNC cycles still owed,
    // RUN cycles spent, and the retry bookkeeping.
    typedef enum int {M_IDLE, M_SYNC, M_RUN, M_DONE, M_FAIL} mphase_t;
    mphase_t m_ph = M_IDLE;
    bit m_fresh = 1'b1;   // reset seen, no clock edge yet: all outputs low
    int m_left = 0, m_run = 0, m_retry = 0, m_tot = 0, m_sel = 0;

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            m_ph <= M_IDLE; m_fresh <= 1'b1; m_left <= 0; m_run <= 0;
            m_retry <= 0; m_tot <= 0; m_sel <= 0;
        end else begin
            m_fresh <= 1'b0;
            case (m_ph)
                M_IDLE: if (AL_DATA_RDY) begin
                    m_sel <= 0; m_retry <= 0; m_tot <= 0;
                    m_ph <= M_SYNC; m_left <= SYNC_CYC;
                end
                M_SYNC: begin
                    if (m_left == 1) begin m_ph <= M_RUN; m_run <= 0; end
                    else m_left <= m_left - 1;
                end
                M_RUN: begin
                    m_run <= m_run + 1;
                    if (SEQ_ERR || (!SEQ_DONE && (m_run + 1 == TMO_CYC))) begin
                        if (m_retry < MAX_RETRY) begin
                            m_retry <= m_retry + 1;
                            m_tot <= (m_tot < 255) ? m_tot + 1 : 255;
                            m_ph <= M_SYNC; m_left <= SYNC_CYC;
                        end else begin
                            m_ph <= M_FAIL;
                        end
                    end else if (SEQ_DONE) begin
                        if (m_sel == NSEQ - 1) m_ph <= M_DONE;
                        else begin
                            m_sel <= m_sel + 1; m_retry <= 0;
                            m_ph <= M_SYNC; m_left <= SYNC_CYC;
                        end
                    end
                end
                default: if (REARM) m_ph <= M_IDLE;
            endcase
        end
    end

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endfunction

    function automatic void compare_all();
        logic [5:0] e_flags, a_flags;
        if (m_fresh) e_flags = '0;
        else e_flags = {(m_ph == M_IDLE) || (m_ph == M_DONE) || (m_ph == M_FAIL),
                        (m_ph == M_SYNC), (m_ph == M_RUN),
                        (m_ph == M_SYNC) || (m_ph == M_RUN),
                        (m_ph == M_DONE), (m_ph == M_FAIL)};
        a_flags = {CLR_ADDR, SYNC, START_AL, USE_AL_DATA, AL_DONE, AL_FAIL};
        chk("model_flags{clr,sync,start,use,done,fail}", int'(a_flags), int'(e_flags));
        chk("model_seq_sel", int'(SEQ_SEL), m_sel);
        chk("model_retry_tot", int'(RETRY_TOT), m_tot);
    endfunction

    always @(negedge CLK) if (chk_en) compare_all();

    task automatic wait_run();
        int guard;
        guard = 0;
        while (!START_AL && guard < 100) begin guard++; @(negedge CLK); end
        if (!START_AL) chk("wait_start_al_bound", int'(START_AL), 1);
    endtask

    // Wait for RUN counting SYNC cycles, then after dly RUN cycles answer with
    // kind 0 = SEQ_DONE, 1 = SEQ_ERR, 2 = both.
    task automatic respond(input int kind, input int dly, output int sel_seen, output int n_sync);
        int guard;
        n_sync = 0; guard = 0;
        while (!START_AL && guard < 100) begin
            n_sync += int'(SYNC); guard++; @(negedge CLK);
        end
        if (!START_AL) chk("respond_start_al_bound", int'(START_AL), 1);
        sel_seen = int'(SEQ_SEL);
        repeat (dly - 1) @(negedge CLK);
        SEQ_DONE = (kind != 1);
        SEQ_ERR  = (kind != 0);
        @(negedge CLK);
        SEQ_DONE = 1'b0; SEQ_ERR = 1'b0;
    endtask

    task automatic count_run(output int n);
        wait_run();
        n = 0;
        while (START_AL && n < 100) begin n++; @(negedge CLK); end
    endtask

    task automatic start_pass();
        AL_DATA_RDY = 1'b1; @(negedge CLK); AL_DATA_RDY = 1'b0;
    endtask

    task automatic rearm();
        REARM = 1'b1; @(negedge CLK); REARM = 1'b0;
        chk("rearm_clr_addr_high", int'(CLR_ADDR), 1);
        chk("rearm_done_fail_low", int'({AL_DONE, AL_FAIL}), 0);
        @(negedge CLK);
    endtask

    int retry_kind[6] = '{0, 1, 1, 0, 0, 0};
    int retry_sel[6]  = '{0, 1, 1, 1, 2, 3};

    initial begin
        int sel, ns, n;
        #2 RST_N = 1'b0;
        chk_en = 1'b1;
        repeat (2) @(negedge CLK);
        chk("reset_outputs_zero", int'({CLR_ADDR, SYNC, START_AL, USE_AL_DATA, AL_DONE, AL_FAIL}), 0);
        RST_N = 1'b1;
        @(negedge CLK);
        chk("idle_clr_addr", int'(CLR_ADDR), 1);
        chk("idle_quiet", int'({SYNC, START_AL, USE_AL_DATA, AL_DONE, AL_FAIL}), 0);
        @(negedge CLK);

        // Full pass, every sequence answered after 5 RUN cycles.
        start_pass();
        for (int s = 0; s < NSEQ; s++) begin
            respond(0, 5, sel, ns);
            chk("pass_seq_sel", sel, s);
            chk("pass_sync_cycles", ns, SYNC_CYC);
        end
        chk("pass_al_done", int'(AL_DONE), 1);
        chk("pass_retry_tot", int'(RETRY_TOT), 0);
        rearm();

        // Two errors on sequence 1, then success.
        start_pass();
        for (int r = 0; r < 6; r++) begin
            respond(retry_kind[r], 5, sel, ns);
            chk("retry_seq_sel", sel, retry_sel[r]);
            chk("retry_sync_cycles", ns, SYNC_CYC);
        end
        chk("retry_al_done", int'(AL_DONE), 1);
        chk("retry_retry_tot", int'(RETRY_TOT), 2);
        rearm();

        // No answer at all: every round times out, then FAIL.
        start_pass();
        for (int r = 0; r <= MAX_RETRY; r++) begin
            count_run(n);
            chk("timeout_start_al_cycles", n, 16);
        end
        chk("timeout_al_fail", int'(AL_FAIL), 1);
        chk("timeout_seq_sel", int'(SEQ_SEL), 0);
        chk("timeout_retry_tot", int'(RETRY_TOT), 2);
        rearm();

        // DONE+ERR together retries; DONE on the terminal watchdog cycle succeeds.
        start_pass();
        respond(2, 3, sel, ns);
        chk("simul_retry_tot", int'(RETRY_TOT), 1);
        respond(0, TMO_CYC, sel, ns);
        chk("simul_same_seq", sel, 0);
        chk("terminal_done_advances", int'(SEQ_SEL), 1);
        for (int s = 1; s < NSEQ; s++) respond(0, 2, sel, ns);
        chk("simul_al_done", int'(AL_DONE), 1);
        // Data ready held through REARM: one IDLE cycle, then SYNC.
        AL_DATA_RDY = 1'b1; REARM = 1'b1;
        @(negedge CLK);
        REARM = 1'b0;
        chk("held_rdy_idle_cycle", int'({CLR_ADDR, SYNC}), 2);
        @(negedge CLK);
        AL_DATA_RDY = 1'b0;
        chk("held_rdy_sync", int'(SYNC), 1);

        // Reset while running sequence 1.
        respond(1, 4, sel, ns);
        respond(0, 4, sel, ns);
        wait_run();
        #2 RST_N = 1'b0;
        #1 compare_all();
        chk("async_rst_start_al", int'(START_AL), 0);
        chk("async_rst_seq_sel", int'(SEQ_SEL), 0);
        chk("async_rst_clr_addr", int'(CLR_ADDR), 0);
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        chk("post_rst_clr_addr", int'(CLR_ADDR), 1);
        chk("post_rst_seq_sel", int'(SEQ_SEL), 0);

        // Random traffic against the model.
        for (int i = 0; i < 5000; i++) begin
            AL_DATA_RDY = ($urandom_range(0, 99) < 20);
            SEQ_DONE    = ($urandom_range(0, 99) < 12);
            SEQ_ERR     = ($urandom_range(0, 99) < 4);
            REARM       = ($urandom_range(0, 99) < 15);
            if ($urandom_range(0, 999) == 0) begin
                #2 RST_N = 1'b0;
                #1 compare_all();
                @(negedge CLK);
                RST_N = 1'b1;
            end else begin
                @(negedge CLK);
            end
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL global_timeout: got no finish, expected finish by t=%0t", $time);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "simulation time limit reached");
    end

endmodule
